hog_cell_hist: RTL

Per-cell orientation histogram accumulator for the HOG pipeline. Consumes a raster-order stream of per-pixel gradient samples (orientation bin, magnitude) from the gradient stage. Sums magnitudes into a 9-bin histogram for every CELL_W x CELL_H cell of the current cell row. At the end of each cell row it drains the CELLS_X finished histograms, in column order 0..CELLS_X-1, to the downstream cell/block stage, one cell per handshake.

---
 rtl/hog_cell_hist.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hog_cell_hist.sv
// rtl/hog_cell_hist.sv - per-cell 9-bin HOG orientation histogram accumulator with cell-row drain
module hog_cell_hist #(
    parameter int CELLS_X = 53,
    parameter int CELLS_Y = 60,
    parameter int CELL_W  = 8,
    parameter int CELL_H  = 8,
    parameter int MAG_W   = 8,
    parameter int NBINS   = 9,
    parameter int ACC_W   = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_bin,
    input  logic [MAG_W-1:0]       in_mag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NBINS*ACC_W-1:0] out_hist,
    output logic [5:0]             out_cell_col,
    output logic [7:0]             out_cell_row,
    output logic                   out_last
);

    localparam int XW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int YW = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam logic [XW-1:0] LAST_X   = XW'(CELL_W - 1);
    localparam logic [YW-1:0] LAST_Y   = YW'(CELL_H - 1);
    localparam logic [5:0]    LAST_COL = 6'(CELLS_X - 1);
    localparam logic [7:0]    LAST_ROW = 8'(CELLS_Y - 1);
    localparam logic [3:0]    NBINS_L  = 4'(NBINS);

    typedef enum logic {ACCUM, DRAIN} state_e;

    state_e                   state_q;
    logic [ACC_W-1:0]         acc_q [CELLS_X][NBINS];
    logic [XW-1:0]            x_in_cell_q;
    logic [5:0]               cell_x_q;
    logic [YW-1:0]            y_in_cell_q;
    logic [7:0]               cell_row_q;
    logic [5:0]               drain_idx_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic [NBINS*ACC_W-1:0]   out_hist_q;
    logic [5:0]               out_cell_col_q;
    logic [7:0]               out_cell_row_q;
    logic                     out_last_q;

    logic                     in_fire;
    logic                     bin_ok;
    logic                     row_end;
    logic [ACC_W-1:0]         mag_ext;
    logic [5:0]               col_d;
    logic [NBINS*ACC_W-1:0]   hist_d;
    logic                     last_d;

    assign in_fire = (state_q == ACCUM) && in_valid && in_ready_q;
    assign bin_ok  = (in_bin < NBINS_L);
    assign row_end = (x_in_cell_q == LAST_X) && (cell_x_q == LAST_COL) && (y_in_cell_q == LAST_Y);
    assign mag_ext = {{(ACC_W-MAG_W){1'b0}}, in_mag};

    // Next histogram to present: column 0 on drain entry, otherwise the column after the one
    // being handed off. The bypass folds in a sample landing on that column at the same edge.
    always_comb begin
        col_d = 6'd0;
        if (state_q == DRAIN && drain_idx_q != LAST_COL) begin
            col_d = drain_idx_q + 6'd1;
        end
        hist_d = '0;
        for (int k = 0; k < NBINS; k++) begin
            hist_d[k*ACC_W +: ACC_W] = acc_q[col_d][k] +
                ((in_fire && bin_ok && cell_x_q == col_d && in_bin == 4'(k)) ? mag_ext : '0);
        end
        last_d = (col_d == LAST_COL) && (cell_row_q == LAST_ROW);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ACCUM;
            x_in_cell_q    <= '0;
            cell_x_q       <= '0;
            y_in_cell_q    <= '0;
            cell_row_q     <= '0;
            drain_idx_q    <= '0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_hist_q     <= '0;
            out_cell_col_q <= '0;
            out_cell_row_q <= '0;
            out_last_q     <= 1'b0;
            for (int c = 0; c < CELLS_X; c++) begin
                for (int k = 0; k < NBINS; k++) begin
                    acc_q[c][k] <= '0;
                end
            end
        end else begin
            case (state_q)
                ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        if (bin_ok) begin
                            acc_q[cell_x_q][in_bin] <= acc_q[cell_x_q][in_bin] + mag_ext;
                        end
                        if (x_in_cell_q == LAST_X) begin
                            x_in_cell_q <= '0;
                            if (cell_x_q == LAST_COL) begin
                                cell_x_q <= '0;
                                if (y_in_cell_q == LAST_Y) begin
                                    y_in_cell_q <= '0;
                                end else begin
                                    y_in_cell_q <= y_in_cell_q + 1'b1;
                                end
                            end else begin
                                cell_x_q <= cell_x_q + 6'd1;
                            end
                        end else begin
                            x_in_cell_q <= x_in_cell_q + 1'b1;
                        end
                        if (row_end) begin
                            state_q        <= DRAIN;
                            in_ready_q     <= 1'b0;
                            out_valid_q    <= 1'b1;
                            drain_idx_q    <= '0;
                            out_hist_q     <= hist_d;
                            out_cell_col_q <= col_d;
                            out_cell_row_q <= cell_row_q;
                            out_last_q     <= last_d;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        for (int k = 0; k < NBINS; k++) begin
                            acc_q[drain_idx_q][k] <= '0;
                        end
                        if (drain_idx_q == LAST_COL) begin
                            drain_idx_q <= '0;
                            cell_row_q  <= (cell_row_q == LAST_ROW) ? 8'd0 : cell_row_q + 8'd1;
                            state_q     <= ACCUM;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            drain_idx_q    <= drain_idx_q + 6'd1;
                            out_hist_q     <= hist_d;
                            out_cell_col_q <= col_d;
                            out_last_q     <= last_d;
                        end
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_hist     = out_hist_q;
    assign out_cell_col = out_cell_col_q;
    assign out_cell_row = out_cell_row_q;
    assign out_last     = out_last_q;

endmodule
